// File: rtl/cordic_sched_pkg.sv
// Shared types and defaults for the two-port CORDIC issue scheduler.
package cordic_sched_pkg;

    localparam int LATENCY_DEFAULT = 47;
    localparam int THETA_W         = 32;

    typedef logic tag_t;

    typedef struct packed {
        logic valid;
        tag_t tag;
    } track_t;

endpackage

// File: rtl/sched_fifo.sv
// Synchronous first-word-fall-through response FIFO with occupancy count.
module sched_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             pop;

    // A pop against an empty FIFO is ignored.
    assign pop = rd_en && (count_reg != '0);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (wr_en && !pop) begin
                count_reg <= count_reg + CNT_W'(1);
            end else if (pop && !wr_en) begin
                count_reg <= count_reg - CNT_W'(1);
            end
        end
    end

    // Head is forced to zero when empty so the output is clean during reset.
    assign rd_valid = (count_reg != '0);
    assign rd_data  = rd_valid ? mem[rd_ptr_reg] : '0;
    assign count    = count_reg;

endmodule

// File: rtl/cordic_sched.sv
// Round-robin, credit-limited issue of two requesters onto one pipelined CORDIC,
// with per-port response FIFOs filled from a latency-matched tag pipeline.
module cordic_sched
    import cordic_sched_pkg::*;
#(
    parameter int LATENCY    = LATENCY_DEFAULT,
    parameter int FIFO_DEPTH = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               req0_valid,
    input  logic [THETA_W-1:0] req0_theta,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [THETA_W-1:0] req1_theta,
    output logic               req1_ready,
    output logic               rsp0_valid,
    output logic [THETA_W-1:0] rsp0_data,
    input  logic               rsp0_ready,
    output logic               rsp1_valid,
    output logic [THETA_W-1:0] rsp1_data,
    input  logic               rsp1_ready,
    output logic [THETA_W-1:0] cordic_theta,
    input  logic [THETA_W-1:0] cordic_result,
    output logic               busy
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [1:0]         elig;
    logic [1:0]         accept;
    logic [1:0]         rsp_valid;
    logic [1:0]         rsp_ready;
    logic [1:0]         pop;
    logic [1:0]         fifo_wr;
    logic [THETA_W-1:0] rsp_data   [2];
    logic [CNT_W-1:0]   fifo_count [2];

    logic   run_reg;
    logic   last_grant_reg;
    track_t track_reg [LATENCY];
    track_t track_tail;
    logic   inflight_any;

    assign req_valid = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};

    // Holds ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_reg <= 1'b0;
        end else begin
            run_reg <= 1'b1;
        end
    end

    // Ready never looks at the port's own valid, only at the rival's.
    assign req_ready[0] = elig[0] && !(req_valid[1] && elig[1] && !last_grant_reg);
    assign req_ready[1] = elig[1] && !(req_valid[0] && elig[0] && last_grant_reg);
    assign accept       = req_valid & req_ready;

    always_comb begin
        cordic_theta = '0;
        if (accept[0]) begin
            cordic_theta = req0_theta;
        end else if (accept[1]) begin
            cordic_theta = req1_theta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_reg <= 1'b1;
        end else if (accept[0]) begin
            last_grant_reg <= 1'b0;
        end else if (accept[1]) begin
            last_grant_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                track_reg[i] <= '0;
            end
        end else begin
            track_reg[0] <= '{valid: |accept, tag: tag_t'(accept[1])};
            for (int i = 1; i < LATENCY; i++) begin
                track_reg[i] <= track_reg[i-1];
            end
        end
    end

    assign track_tail = track_reg[LATENCY-1];

    always_comb begin
        inflight_any = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight_any = inflight_any | track_reg[i].valid;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            logic [CNT_W-1:0] credit_reg;

            // Credit covers ops in flight plus FIFO occupancy, so a tail write never overflows.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    credit_reg <= '0;
                end else if (accept[gi] && !pop[gi]) begin
                    credit_reg <= credit_reg + CNT_W'(1);
                end else if (pop[gi] && !accept[gi]) begin
                    credit_reg <= credit_reg - CNT_W'(1);
                end
            end

            assign elig[gi]    = run_reg && (credit_reg < CNT_W'(FIFO_DEPTH));
            assign fifo_wr[gi] = track_tail.valid && (track_tail.tag == tag_t'(gi));
            assign pop[gi]     = rsp_ready[gi] && rsp_valid[gi];

            sched_fifo #(
                .DEPTH (FIFO_DEPTH),
                .WIDTH (THETA_W),
                .CNT_W (CNT_W)
            ) u_fifo (
                .clk      (clk),
                .reset_n  (reset_n),
                .wr_en    (fifo_wr[gi]),
                .wr_data  (cordic_result),
                .rd_en    (rsp_ready[gi]),
                .rd_valid (rsp_valid[gi]),
                .rd_data  (rsp_data[gi]),
                .count    (fifo_count[gi])
            );
        end
    endgenerate

    assign req0_ready = req_ready[0];
    assign req1_ready = req_ready[1];
    assign rsp0_valid = rsp_valid[0];
    assign rsp1_valid = rsp_valid[1];
    assign rsp0_data  = rsp_data[0];
    assign rsp1_data  = rsp_data[1];
    assign busy       = inflight_any || (fifo_count[0] != '0) || (fifo_count[1] != '0);

endmodule

// File: tb/tb_cordic_sched.sv
// Directed self-checking bench for cordic_sched; the CORDIC is a LATENCY-stage delay line.
module tb_cordic_sched;
    import cordic_sched_pkg::*;

    localparam int LATENCY    = LATENCY_DEFAULT;
    localparam int FIFO_DEPTH = 64;

    logic        clk;
    logic        reset_n;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_theta, req1_theta;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_data, rsp1_data;
    logic        rsp0_ready, rsp1_ready;
    logic [31:0] cordic_theta, cordic_result;
    logic        busy;

    logic [31:0] pipe [LATENCY];

    int checks = 0;
    int errors = 0;

    cordic_sched #(
        .LATENCY    (LATENCY),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req0_valid    (req0_valid),
        .req0_theta    (req0_theta),
        .req0_ready    (req0_ready),
        .req1_valid    (req1_valid),
        .req1_theta    (req1_theta),
        .req1_ready    (req1_ready),
        .rsp0_valid    (rsp0_valid),
        .rsp0_data     (rsp0_data),
        .rsp0_ready    (rsp0_ready),
        .rsp1_valid    (rsp1_valid),
        .rsp1_data     (rsp1_data),
        .rsp1_ready    (rsp1_ready),
        .cordic_theta  (cordic_theta),
        .cordic_result (cordic_result),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CORDIC stand-in: result equals theta, LATENCY edges later; never reset.
    initial begin
        for (int i = 0; i < LATENCY; i++) pipe[i] = '0;
    end
    always @(posedge clk) begin
        pipe[0] <= cordic_theta;
        for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
    assign cordic_result = pipe[LATENCY-1];

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0;
        req0_theta = '0; req1_theta = '0;
        rsp0_ready = 0; rsp1_ready = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 0;
        repeat (2) step();
        reset_n = 1;
        step();
    endtask

    task automatic test_reset();
        reset_n = 0;
        req0_valid = 1; req1_valid = 1;
        req0_theta = 32'h1234_5678; req1_theta = 32'h9abc_def0;
        rsp0_ready = 1; rsp1_ready = 1;
        repeat (2) step();
        #1;
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL rst_req0_ready got %b want 0", req0_ready); end
        checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL rst_req1_ready got %b want 0", req1_ready); end
        checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b%b want 00", rsp1_valid, rsp0_valid); end
        checks++; if (rsp0_data !== 32'h0 || rsp1_data !== 32'h0) begin errors++; $display("FAIL rst_rsp_data got %h %h want 0", rsp0_data, rsp1_data); end
        checks++; if (cordic_theta !== 32'h0) begin errors++; $display("FAIL rst_cordic_theta got %h want 0", cordic_theta); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        reset_n = 1;
        #1;
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL rst_release_ready got %b%b want 00", req1_ready, req0_ready); end
        step();
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL rst_first_grant got r1=%b r0=%b want r1=0 r0=1", req1_ready, req0_ready); end
        idle_inputs();
        $display("test_reset done");
    endtask

    task automatic test_single();
        do_reset();
        req0_valid = 1; req0_theta = 32'h3f49_0fdb;
        #1;
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b want 1", req0_ready); end
        checks++; if (cordic_theta !== 32'h3f49_0fdb) begin errors++; $display("FAIL single_theta got %h want 3f490fdb", cordic_theta); end
        step();
        req0_valid = 0; req0_theta = '0;
        #1;
        checks++; if (cordic_theta !== 32'h0) begin errors++; $display("FAIL single_theta_idle got %h want 0", cordic_theta); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_flight got %b want 1", busy); end
        repeat (LATENCY - 1) step();
        #1;
        checks++; if (rsp0_valid !== 1'b0) begin errors++; $display("FAIL single_early got rsp0_valid=%b want 0", rsp0_valid); end
        step();
        #1;
        checks++; if (rsp0_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", rsp0_valid); end
        checks++; if (rsp0_data !== 32'h3f49_0fdb) begin errors++; $display("FAIL single_data got %h want 3f490fdb", rsp0_data); end
        checks++; if (rsp1_valid !== 1'b0) begin errors++; $display("FAIL single_rsp1 got %b want 0", rsp1_valid); end
        rsp0_ready = 1;
        step();
        rsp0_ready = 0;
        #1;
        checks++; if (rsp0_valid !== 1'b0) begin errors++; $display("FAIL single_popped got %b want 0", rsp0_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle got %b want 0", busy); end
        $display("test_single done");
    endtask

    task automatic test_contention();
        idle_inputs();
        reset_n = 0;
        req0_valid = 1; req0_theta = 32'h1;
        req1_valid = 1; req1_theta = 32'h2;
        repeat (2) step();
        reset_n = 1;
        step();
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
                errors++; $display("FAIL contention_grant%0d got r0=%b r1=%b want p%0d", i, req0_ready, req1_ready, i % 2);
            end
            checks++;
            if (cordic_theta !== ((i % 2 == 0) ? 32'h1 : 32'h2)) begin
                errors++; $display("FAIL contention_theta%0d got %h", i, cordic_theta);
            end
            step();
        end
        req0_valid = 0; req1_valid = 0;
        repeat (LATENCY) step();
        for (int j = 0; j < 2; j++) begin
            #1;
            checks++;
            if (rsp0_valid !== 1'b1 || rsp0_data !== 32'h1) begin
                errors++; $display("FAIL contention_rsp0_%0d got v=%b d=%h want v=1 d=1", j, rsp0_valid, rsp0_data);
            end
            checks++;
            if (rsp1_valid !== 1'b1 || rsp1_data !== 32'h2) begin
                errors++; $display("FAIL contention_rsp1_%0d got v=%b d=%h want v=1 d=2", j, rsp1_valid, rsp1_data);
            end
            rsp0_ready = 1; rsp1_ready = 1;
            step();
            rsp0_ready = 0; rsp1_ready = 0;
        end
        #1;
        checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin errors++; $display("FAIL contention_extra got %b%b want 00", rsp1_valid, rsp0_valid); end
        $display("test_contention done");
    endtask

    // Leaves FIFO 1 full (64 entries 0x2001,0x2003,...) with req1 still valid.
    task automatic test_backpressure();
        int acc0 = 0;
        int acc1 = 0;
        logic [31:0] exp0 [$];
        do_reset();
        rsp0_ready = 1; rsp1_ready = 0;
        req0_valid = 1; req1_valid = 1;
        for (int c = 0; c < 300; c++) begin
            req0_theta = 32'h1000 + c;
            req1_theta = 32'h2000 + c;
            #1;
            if (rsp0_valid) begin
                checks++;
                if (exp0.size() == 0) begin
                    errors++; $display("FAIL bp_rsp0_unexpected got %h want none", rsp0_data);
                end else begin
                    logic [31:0] e = exp0.pop_front();
                    if (rsp0_data !== e) begin errors++; $display("FAIL bp_rsp0_data got %h want %h", rsp0_data, e); end
                end
            end
            if (req0_ready) begin acc0++; exp0.push_back(req0_theta); end
            if (req1_ready) acc1++;
            step();
        end
        req0_valid = 0;
        #1;
        checks++; if (acc1 != FIFO_DEPTH) begin errors++; $display("FAIL bp_acc1 got %0d want %0d", acc1, FIFO_DEPTH); end
        checks++; if (acc0 != 300 - FIFO_DEPTH) begin errors++; $display("FAIL bp_acc0 got %0d want %0d", acc0, 300 - FIFO_DEPTH); end
        checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL bp_req1_ready got %b want 0", req1_ready); end
        $display("test_backpressure done acc0=%0d acc1=%0d", acc0, acc1);
    endtask

    task automatic test_credit_simul();
        int acc1 = 0;
        repeat (LATENCY + 2) step();
        #1;
        checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL credit_full_ready got %b want 0", req1_ready); end
        checks++; if (rsp1_valid !== 1'b1 || rsp1_data !== 32'h2001) begin errors++; $display("FAIL credit_head got v=%b d=%h want v=1 d=2001", rsp1_valid, rsp1_data); end
        rsp1_ready = 1;
        step();
        rsp1_ready = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (req1_ready) acc1++;
            step();
        end
        checks++; if (acc1 != 1) begin errors++; $display("FAIL credit_one_more got %0d accepts want 1", acc1); end
        checks++; if (rsp1_data !== 32'h2003) begin errors++; $display("FAIL credit_next_head got %h want 2003", rsp1_data); end
        req1_valid = 0; rsp1_ready = 1;
        step();
        req1_valid = 1;
        #1;
        checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL credit_room got %b want 1", req1_ready); end
        step();
        rsp1_ready = 0;
        #1;
        checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL credit_same_edge got %b want 1", req1_ready); end
        step();
        req1_valid = 0;
        #1;
        checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL credit_refull got %b want 0", req1_ready); end
        $display("test_credit_simul done");
    endtask

    task automatic test_reset_midflight();
        int bad = 0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            req0_valid = (i % 2 == 0); req1_valid = (i % 2 == 1);
            req0_theta = 32'h3000 + i; req1_theta = 32'h3000 + i;
            step();
        end
        idle_inputs();
        repeat (3) step();
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midreset_busy_before got %b want 1", busy); end
        reset_n = 0;
        repeat (2) step();
        reset_n = 1;
        for (int c = 0; c < 2 * LATENCY; c++) begin
            #1;
            if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || busy !== 1'b0) bad++;
            step();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL midreset_quiet got %0d active cycles want 0", bad); end
        $display("test_reset_midflight done");
    endtask

    task automatic test_throughput();
        int acc = 0;
        logic [31:0] exp0 [$];
        logic [31:0] exp1 [$];
        logic [31:0] e;
        do_reset();
        rsp0_ready = 1; rsp1_ready = 1;
        for (int c = 0; c < 1000 + LATENCY + 2; c++) begin
            if (c < 1000) begin
                req0_valid = (c % 2 == 0); req1_valid = (c % 2 == 1);
                req0_theta = $urandom; req1_theta = $urandom;
            end else begin
                req0_valid = 0; req1_valid = 0;
            end
            #1;
            if (rsp0_valid) begin
                checks++;
                if (exp0.size() == 0) begin errors++; $display("FAIL tp_rsp0_unexpected got %h want none", rsp0_data); end
                else begin e = exp0.pop_front(); if (rsp0_data !== e) begin errors++; $display("FAIL tp_rsp0_data got %h want %h", rsp0_data, e); end end
            end
            if (rsp1_valid) begin
                checks++;
                if (exp1.size() == 0) begin errors++; $display("FAIL tp_rsp1_unexpected got %h want none", rsp1_data); end
                else begin e = exp1.pop_front(); if (rsp1_data !== e) begin errors++; $display("FAIL tp_rsp1_data got %h want %h", rsp1_data, e); end end
            end
            if (req0_valid && req0_ready) begin acc++; exp0.push_back(req0_theta); end
            if (req1_valid && req1_ready) begin acc++; exp1.push_back(req1_theta); end
            step();
        end
        checks++; if (acc != 1000) begin errors++; $display("FAIL tp_accepts got %0d want 1000", acc); end
        checks++; if (exp0.size() != 0 || exp1.size() != 0) begin errors++; $display("FAIL tp_leftover got %0d/%0d want 0/0", exp0.size(), exp1.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tp_busy_end got %b want 0", busy); end
        idle_inputs();
        $display("test_throughput done accepts=%0d", acc);
    endtask

    initial begin
        idle_inputs();
        reset_n = 0;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_credit_simul();
        test_reset_midflight();
        test_throughput();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
